// File: rtl/cache_ram_pkg.sv
// Shared types and helpers for the cache data RAM family.
// Imported by the N-read/1-write array and its read ports.
package cache_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    function automatic int calc_aw(
        input int set_w,
        input int way_w,
        input int word_w
    );
        return set_w + way_w + word_w;
    endfunction

    function automatic logic [7:0] byte_merge(
        input logic [7:0] old_b,
        input logic [7:0] new_b,
        input logic       be
    );
        return be ? new_b : old_b;
    endfunction

endpackage

// File: rtl/cache_ram_rd_port.sv
// One read port: samples the array with optional same-cycle
// write forwarding, then an optional second output stage.
module cache_ram_rd_port
    import cache_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int AW         = 10,
    parameter int RD_LAT     = 1,
    parameter int BYPASS     = 1,
    localparam int NB        = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_acc,
    input  logic [AW-1:0]         rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_raw,
    input  logic                  wr_act,
    input  logic [AW-1:0]         wr_addr,
    input  logic [NB-1:0]         wr_be,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    logic                  hit;
    logic [DATA_WIDTH-1:0] fwd;
    logic                  s1_valid_d;
    logic                  s1_valid_q;
    logic [DATA_WIDTH-1:0] s1_data_d;
    logic [DATA_WIDTH-1:0] s1_data_q;

    // rd_raw is the pre-write array contents, so read-first needs no merge
    always_comb begin
        hit = (BYPASS != 0) && wr_act && (wr_addr == rd_addr);
        fwd = rd_raw;
        for (int b = 0; b < NB; b++) begin
            fwd[b*8 +: 8] = byte_merge(rd_raw[b*8 +: 8],
                                       wr_data[b*8 +: 8],
                                       hit && wr_be[b]);
        end
        s1_valid_d = rd_acc;
        s1_data_d  = rd_acc ? fwd : s1_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic                  s2_valid_d;
        logic                  s2_valid_q;
        logic [DATA_WIDTH-1:0] s2_data_d;
        logic [DATA_WIDTH-1:0] s2_data_q;

        always_comb begin
            s2_valid_d = s1_valid_q;
            s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= '0;
            end else begin
                s2_valid_q <= s2_valid_d;
                s2_data_q  <= s2_data_d;
            end
        end

        assign rd_data  = s2_data_q;
        assign rd_valid = s2_valid_q;
    end else begin : g_lat1
        assign rd_data  = s1_data_q;
        assign rd_valid = s1_valid_q;
    end

endmodule

// File: rtl/cache_data_ram_nr1w.sv
// N-read/1-write byte-enabled cache data array with a
// hardware clear sweep after reset.
module cache_data_ram_nr1w
    import cache_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SET_WIDTH  = 4,
    parameter int WAY_WIDTH  = 2,
    parameter int WORD_WIDTH = 4,
    parameter int NUM_RD     = 2,
    parameter int RD_LAT     = 1,
    parameter int BYPASS     = 1,
    localparam int AW        = calc_aw(SET_WIDTH, WAY_WIDTH, WORD_WIDTH),
    localparam int DEPTH     = 2 ** AW,
    localparam int NB        = DATA_WIDTH / 8
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         busy,
    input  logic                         w_en,
    input  logic [NB-1:0]                w_be,
    input  logic [AW-1:0]                w_addr,
    input  logic [DATA_WIDTH-1:0]        w_data,
    input  logic [NUM_RD-1:0]            r_en,
    input  logic [NUM_RD*AW-1:0]         r_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] r_data,
    output logic [NUM_RD-1:0]            r_valid
);

    state_e                state_q;
    state_e                state_d;
    logic [AW-1:0]         cnt_q;
    logic [AW-1:0]         cnt_d;
    logic                  ready;
    logic                  wr_act;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign ready  = (state_q == READY);
    assign busy   = ~ready;
    assign wr_act = ready && w_en;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) begin
                state_d = READY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        wr_merged = mem[w_addr];
        for (int b = 0; b < NB; b++) begin
            wr_merged[b*8 +: 8] = byte_merge(mem[w_addr][b*8 +: 8],
                                             w_data[b*8 +: 8],
                                             w_be[b]);
        end
    end

    // The sweep owns the write port until the last entry is zeroed
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!ready) begin
                mem[cnt_q] <= '0;
            end else if (w_en) begin
                mem[w_addr] <= wr_merged;
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]         addr;
        logic [DATA_WIDTH-1:0] raw;

        assign addr = r_addr[p*AW +: AW];
        assign raw  = mem[addr];

        cache_ram_rd_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .AW         (AW),
            .RD_LAT     (RD_LAT),
            .BYPASS     (BYPASS)
        ) u_rd (
            .clk      (clk),
            .rst      (rst),
            .rd_acc   (ready && r_en[p]),
            .rd_addr  (addr),
            .rd_raw   (raw),
            .wr_act   (wr_act),
            .wr_addr  (w_addr),
            .wr_be    (w_be),
            .wr_data  (w_data),
            .rd_data  (r_data[p*DATA_WIDTH +: DATA_WIDTH]),
            .rd_valid (r_valid[p])
        );
    end

endmodule
